// File: rtl/rv32_mem_stage.sv
// rv32_mem_stage: MEM stage with byte-lane store alignment, load extraction and misalignment exceptions
//   EX side  : ex_valid/ex_ready handshake plus EX/MEM fields (address, store data, rd, control)
//   dmem side: single outstanding req/gnt then rvalid/rdata, word-aligned address with byte enables
//   WB side  : registered one-cycle wb_valid pulse with result/rd/reg_write
//   exc side : registered one-cycle exc_valid pulse with cause (4 load, 6 store) and faulting address
module rv32_mem_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_valid,
    output logic            ex_ready,
    input  logic [XLEN-1:0] ex_alu_result,
    input  logic [XLEN-1:0] ex_rs2_data,
    input  logic [4:0]      ex_rd_addr,
    input  logic            ex_reg_write,
    input  logic            ex_mem_read,
    input  logic            ex_mem_write,
    input  logic [1:0]      ex_mem_size,
    input  logic            ex_mem_unsigned,
    input  logic            flush,
    output logic            dmem_req,
    input  logic            dmem_gnt,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [3:0]      dmem_be,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic            dmem_rvalid,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            wb_valid,
    output logic [XLEN-1:0] wb_result,
    output logic [4:0]      wb_rd_addr,
    output logic            wb_reg_write,
    output logic            exc_valid,
    output logic [3:0]      exc_cause,
    output logic [XLEN-1:0] exc_tval
);
    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
    state_t state;
    logic [1:0] lane_q;
    logic [1:0] size_q;
    logic [4:0] rd_q;
    logic rw_q;
    logic load_q;
    logic uns_q;
    logic killed_q;
    logic accept;
    logic is_mem;
    logic misaligned;
    logic [1:0] lane;
    logic [3:0] be_n;
    logic [XLEN-1:0] wdata_n;
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] load_val;
    assign ex_ready = state == IDLE;
    always_comb begin
        accept = ex_valid && ex_ready && !flush;
        is_mem = ex_mem_read || ex_mem_write;
        lane = ex_alu_result[1:0];
        misaligned = ex_mem_size == 2'd0 ? 1'b0 : ex_mem_size == 2'd1 ? lane[0] : lane != 2'b00;
        be_n = ex_mem_size == 2'd0 ? 4'b0001 << lane : ex_mem_size == 2'd1 ? 4'b0011 << lane : 4'b1111;
        wdata_n = ex_mem_size == 2'd0 ? {4{ex_rs2_data[7:0]}} :
                  ex_mem_size == 2'd1 ? {2{ex_rs2_data[15:0]}} : ex_rs2_data;
        // move the addressed lane down to bit 0, then extend from the access width
        shifted = dmem_rdata >> {lane_q, 3'b000};
        load_val = size_q == 2'd0 ? {{24{!uns_q && shifted[7]}}, shifted[7:0]} :
                   size_q == 2'd1 ? {{16{!uns_q && shifted[15]}}, shifted[15:0]} : shifted;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            lane_q <= '0;
            size_q <= '0;
            rd_q <= '0;
            rw_q <= 1'b0;
            load_q <= 1'b0;
            uns_q <= 1'b0;
            killed_q <= 1'b0;
            dmem_req <= 1'b0;
            dmem_we <= 1'b0;
            dmem_addr <= '0;
            dmem_be <= '0;
            dmem_wdata <= '0;
            wb_valid <= 1'b0;
            wb_result <= '0;
            wb_rd_addr <= '0;
            wb_reg_write <= 1'b0;
            exc_valid <= 1'b0;
            exc_cause <= '0;
            exc_tval <= '0;
        end else begin
            wb_valid <= 1'b0;
            exc_valid <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    if (!is_mem) begin
                        wb_valid <= 1'b1;
                        wb_result <= ex_alu_result;
                        wb_rd_addr <= ex_rd_addr;
                        wb_reg_write <= ex_reg_write && ex_rd_addr != 5'd0;
                    end else if (misaligned) begin
                        exc_valid <= 1'b1;
                        exc_cause <= ex_mem_read ? 4'd4 : 4'd6;
                        exc_tval <= ex_alu_result;
                    end else begin
                        lane_q <= lane;
                        size_q <= ex_mem_size;
                        rd_q <= ex_rd_addr;
                        rw_q <= ex_reg_write;
                        load_q <= ex_mem_read;
                        uns_q <= ex_mem_unsigned;
                        killed_q <= 1'b0;
                        dmem_req <= 1'b1;
                        dmem_we <= ex_mem_write;
                        dmem_addr <= {ex_alu_result[XLEN-1:2], 2'b00};
                        dmem_be <= be_n;
                        dmem_wdata <= wdata_n;
                        state <= REQ;
                    end
                end
                REQ: if (dmem_gnt) begin
                    // a granted access always completes; flush only suppresses its retirement
                    dmem_req <= 1'b0;
                    killed_q <= flush;
                    state <= load_q ? RESP : IDLE;
                    if (!load_q && !flush) begin
                        wb_valid <= 1'b1;
                        wb_rd_addr <= rd_q;
                        wb_reg_write <= 1'b0;
                    end
                end else if (flush) begin
                    dmem_req <= 1'b0;
                    state <= IDLE;
                end
                RESP: if (dmem_rvalid) begin
                    state <= IDLE;
                    if (!killed_q && !flush) begin
                        wb_valid <= 1'b1;
                        wb_result <= load_val;
                        wb_rd_addr <= rd_q;
                        wb_reg_write <= rw_q && rd_q != 5'd0;
                    end
                end else if (flush) begin
                    killed_q <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rv32_mem_stage.sv
// tb_rv32_mem_stage: randomized bench for rv32_mem_stage against a byte-level behavioural model
module tb_rv32_mem_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ex_valid = 1'b0;
    logic ex_ready;
    logic [31:0] ex_alu_result = '0;
    logic [31:0] ex_rs2_data = '0;
    logic [4:0] ex_rd_addr = '0;
    logic ex_reg_write = 1'b0;
    logic ex_mem_read = 1'b0;
    logic ex_mem_write = 1'b0;
    logic [1:0] ex_mem_size = '0;
    logic ex_mem_unsigned = 1'b0;
    logic flush = 1'b0;
    logic dmem_req;
    logic dmem_gnt = 1'b0;
    logic dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0] dmem_be;
    logic [31:0] dmem_wdata;
    logic dmem_rvalid = 1'b0;
    logic [31:0] dmem_rdata = '0;
    logic wb_valid;
    logic [31:0] wb_result;
    logic [4:0] wb_rd_addr;
    logic wb_reg_write;
    logic exc_valid;
    logic [3:0] exc_cause;
    logic [31:0] exc_tval;

    rv32_mem_stage #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_alu_result(ex_alu_result), .ex_rs2_data(ex_rs2_data), .ex_rd_addr(ex_rd_addr),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_mem_size(ex_mem_size), .ex_mem_unsigned(ex_mem_unsigned), .flush(flush),
        .dmem_req(dmem_req), .dmem_gnt(dmem_gnt), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_rvalid(dmem_rvalid),
        .dmem_rdata(dmem_rdata), .wb_valid(wb_valid), .wb_result(wb_result),
        .wb_rd_addr(wb_rd_addr), .wb_reg_write(wb_reg_write), .exc_valid(exc_valid),
        .exc_cause(exc_cause), .exc_tval(exc_tval)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        bit exc;
        bit full;
        logic [31:0] val;
        logic [4:0] rd;
        bit rw;
        logic [3:0] cause;
    } exp_t;

    exp_t exp_q[$];
    int cyc = 0;
    int checks = 0;
    int errors = 0;
    logic [31:0] last_addr;
    logic [31:0] last_wdata;
    logic [3:0] last_be;
    logic last_we;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int nbytes(input logic [1:0] sz);
        return sz == 2'd0 ? 1 : sz == 2'd1 ? 2 : 4;
    endfunction

    function automatic logic [3:0] model_be(input logic [1:0] sz, input int lane);
        logic [3:0] be;
        for (int i = 0; i < 4; i++) be[i] = i >= lane && i < lane + nbytes(sz);
        return be;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [1:0] sz, input logic [31:0] d);
        logic [31:0] w;
        for (int i = 0; i < 4; i++) w[8*i +: 8] = d[8*(i % nbytes(sz)) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] sz, input logic uns, input int lane,
                                               input logic [31:0] rd);
        logic [31:0] v;
        int nb;
        nb = nbytes(sz);
        v = '0;
        for (int i = 0; i < nb; i++) v = v | (32'(rd[8*(lane+i) +: 8]) << (8*i));
        if (!uns && nb < 4 && v[8*nb-1]) v = v - (32'd1 << (8*nb));
        return v;
    endfunction

    // every output pulse must match the head of the expectation queue in exactly its cycle
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            e = exp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL missed_pulse: expected in cycle %0d", e.cyc);
        end
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            e = exp_q.pop_front();
            if (e.exc) begin
                chk("exc_valid", exc_valid, 1);
                chk("exc_wb_valid", wb_valid, 0);
                chk("exc_cause", exc_cause, e.cause);
                chk("exc_tval", exc_tval, e.val);
            end else begin
                chk("wb_valid", wb_valid, 1);
                chk("wb_exc_valid", exc_valid, 0);
                chk("wb_reg_write", wb_reg_write, e.rw);
                if (e.full) begin
                    chk("wb_result", wb_result, e.val);
                    chk("wb_rd_addr", wb_rd_addr, e.rd);
                end
            end
        end else begin
            chk("no_wb_pulse", wb_valid, 0);
            chk("no_exc_pulse", exc_valid, 0);
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        ex_valid = 1'b0;
        flush = 1'b0;
        dmem_gnt = 1'b0;
        dmem_rvalid = 1'b0;
        repeat (n) step();
    endtask

    // kind: 0 alu, 1 load, 2 store. fm: 0 none, 1 flush before gnt, 2 flush with gnt,
    // 3 flush in RESP, 4 flush with rvalid, 5 flush at issue, 6 reset in REQ, 7 reset in RESP
    task automatic do_op(input int kind, input logic [1:0] sz, input logic uns, input logic [31:0] a,
                         input logic [31:0] d, input logic [4:0] rd, input logic rw, input int gd,
                         input int lat, input int fm, input logic [31:0] rdv);
        int lane;
        exp_t e;
        lane = int'(a % 4);
        ex_alu_result = a;
        ex_rs2_data = d;
        ex_rd_addr = rd;
        ex_reg_write = rw;
        ex_mem_read = kind == 1;
        ex_mem_write = kind == 2;
        ex_mem_size = sz;
        ex_mem_unsigned = uns;
        ex_valid = 1'b1;
        flush = fm == 5;
        chk("ex_ready_idle", ex_ready, 1);
        if (fm == 5) begin
            step();
            ex_valid = 1'b0;
            flush = 1'b0;
            chk("flush_blocks_req", dmem_req, 0);
            return;
        end
        if (kind == 0) begin
            e = '{cyc + 1, 1'b0, 1'b1, a, rd, rw && rd != 0, 4'd0};
            exp_q.push_back(e);
            step();
            ex_valid = 1'b0;
            return;
        end
        if (a % nbytes(sz) != 0) begin
            e = '{cyc + 1, 1'b1, 1'b1, a, 5'd0, 1'b0, kind == 1 ? 4'd4 : 4'd6};
            exp_q.push_back(e);
            step();
            ex_valid = 1'b0;
            chk("misaligned_no_req", dmem_req, 0);
            return;
        end
        step();
        ex_valid = 1'b0;
        for (int i = 0; ; i++) begin
            chk("dmem_req", dmem_req, 1);
            chk("dmem_addr", dmem_addr, a - (a % 4));
            chk("dmem_be", dmem_be, model_be(sz, lane));
            chk("dmem_we", dmem_we, kind == 2);
            if (kind == 2) chk("dmem_wdata", dmem_wdata, model_wdata(sz, d));
            chk("ex_ready_busy", ex_ready, 0);
            last_addr = dmem_addr;
            last_be = dmem_be;
            last_we = dmem_we;
            last_wdata = dmem_wdata;
            if (i >= gd) break;
            step();
        end
        if (fm == 1) begin
            flush = 1'b1;
            step();
            flush = 1'b0;
            chk("flush_drop_req", dmem_req, 0);
            chk("flush_drop_ready", ex_ready, 1);
            return;
        end
        if (fm == 6) begin
            rst = 1'b1;
            step();
            rst = 1'b0;
            chk("rst_req", dmem_req, 0);
            chk("rst_wb", wb_valid, 0);
            chk("rst_ready", ex_ready, 1);
            return;
        end
        dmem_gnt = 1'b1;
        flush = fm == 2;
        if (kind == 2 && fm != 2) begin
            e = '{cyc + 1, 1'b0, 1'b0, 32'd0, rd, 1'b0, 4'd0};
            exp_q.push_back(e);
        end
        step();
        dmem_gnt = 1'b0;
        flush = 1'b0;
        if (kind == 2) return;
        chk("resp_req_low", dmem_req, 0);
        chk("resp_ready", ex_ready, 0);
        for (int j = 1; j < lat; j++) begin
            flush = fm == 3 && j == 1;
            step();
            flush = 1'b0;
            chk("resp_wait_req", dmem_req, 0);
            chk("resp_wait_ready", ex_ready, 0);
        end
        if (fm == 7) begin
            rst = 1'b1;
            step();
            rst = 1'b0;
            dmem_rvalid = 1'b1;
            dmem_rdata = rdv;
            step();
            dmem_rvalid = 1'b0;
            chk("late_rvalid_wb", wb_valid, 0);
            chk("late_rvalid_ready", ex_ready, 1);
            return;
        end
        dmem_rvalid = 1'b1;
        dmem_rdata = rdv;
        flush = fm == 4;
        if (fm == 0) begin
            e = '{cyc + 1, 1'b0, 1'b1, model_load(sz, uns, lane, rdv), rd, rw && rd != 0, 4'd0};
            exp_q.push_back(e);
        end
        step();
        dmem_rvalid = 1'b0;
        flush = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: no finish by time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int kind;
        int fm;
        int lat;
        logic [1:0] sz;
        logic [31:0] a;
        repeat (3) step();
        rst = 1'b0;
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_wb_result", wb_result, 0);
        chk("rst_wb_rd_addr", wb_rd_addr, 0);
        chk("rst_wb_reg_write", wb_reg_write, 0);
        chk("rst_exc_valid", exc_valid, 0);
        chk("rst_exc_cause", exc_cause, 0);
        chk("rst_exc_tval", exc_tval, 0);
        chk("rst_dmem_req", dmem_req, 0);
        chk("rst_dmem_we", dmem_we, 0);
        chk("rst_dmem_addr", dmem_addr, 0);
        chk("rst_dmem_be", dmem_be, 0);
        chk("rst_dmem_wdata", dmem_wdata, 0);
        chk("rst_ex_ready", ex_ready, 1);
        step();
        do_op(0, 2'd2, 1'b0, 32'h1234, 32'h0, 5'd5, 1'b1, 0, 1, 0, 32'h0);
        chk("alu_lit_result", wb_result, 32'h1234);
        chk("alu_lit_rw", wb_reg_write, 1);
        chk("alu_lit_valid", wb_valid, 1);
        do_op(0, 2'd2, 1'b0, 32'h55, 32'h0, 5'd6, 1'b1, 0, 1, 0, 32'h0);
        chk("alu_b2b_result", wb_result, 32'h55);
        chk("alu_b2b_rd", wb_rd_addr, 6);
        chk("alu_b2b_ready", ex_ready, 1);
        do_op(1, 2'd0, 1'b0, 32'h1003, 32'h0, 5'd9, 1'b1, 0, 1, 0, 32'h80FF_FF11);
        chk("lb_lit_result", wb_result, 32'hFFFF_FF80);
        chk("lb_lit_addr", last_addr, 32'h1000);
        chk("lb_lit_be", last_be, 4'b1000);
        do_op(1, 2'd0, 1'b1, 32'h1003, 32'h0, 5'd9, 1'b1, 1, 2, 0, 32'h80FF_FF11);
        chk("lbu_lit_result", wb_result, 32'h0000_0080);
        do_op(2, 2'd1, 1'b0, 32'h2002, 32'hDEAD_BEEF, 5'd3, 1'b1, 3, 1, 0, 32'h0);
        chk("sh_lit_wdata", last_wdata, 32'hBEEF_BEEF);
        chk("sh_lit_be", last_be, 4'b1100);
        chk("sh_lit_we", last_we, 1);
        chk("sh_lit_valid", wb_valid, 1);
        chk("sh_lit_rw", wb_reg_write, 0);
        do_op(1, 2'd2, 1'b0, 32'h3006, 32'h0, 5'd4, 1'b1, 0, 1, 0, 32'h0);
        chk("lw_mis_lit_valid", exc_valid, 1);
        chk("lw_mis_lit_cause", exc_cause, 4);
        chk("lw_mis_lit_tval", exc_tval, 32'h3006);
        do_op(2, 2'd2, 1'b0, 32'h3001, 32'h0, 5'd4, 1'b0, 0, 1, 0, 32'h0);
        chk("sw_mis_lit_cause", exc_cause, 6);
        chk("sw_mis_lit_tval", exc_tval, 32'h3001);
        do_op(1, 2'd2, 1'b0, 32'h4000, 32'h0, 5'd7, 1'b1, 0, 2, 3, 32'h1234_5678);
        chk("flush_resp_wb", wb_valid, 0);
        chk("flush_resp_ready", ex_ready, 1);
        do_op(1, 2'd2, 1'b0, 32'h5000, 32'h0, 5'd8, 1'b1, 1, 1, 6, 32'h0);
        do_op(1, 2'd2, 1'b0, 32'h6000, 32'h0, 5'd0, 1'b1, 0, 1, 0, 32'hCAFE_F00D);
        chk("ld_x0_valid", wb_valid, 1);
        chk("ld_x0_rw", wb_reg_write, 0);
        chk("ld_x0_result", wb_result, 32'hCAFE_F00D);
        for (int n = 0; n < 400; n++) begin
            kind = $urandom_range(0, 2);
            sz = 2'($urandom_range(0, 3));
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = sz == 2'd0 ? a[1:0] : sz == 2'd1 ? {a[1], 1'b0} : 2'b00;
            fm = $urandom_range(0, 9) > 6 ? $urandom_range(1, 7) : 0;
            if (kind == 2 && (fm == 3 || fm == 4 || fm == 7)) fm = 0;
            if (kind == 0 && fm != 5) fm = 0;
            lat = $urandom_range(1, 3);
            if (fm == 3 && lat < 2) lat = 2;
            do_op(kind, sz, 1'($urandom_range(0, 1)), a, $urandom, 5'($urandom_range(0, 31)),
                  1'($urandom_range(0, 1)), $urandom_range(0, 3), lat, fm, $urandom);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end
        idle(4);
        chk("pending_expectations", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
